// File: rtl/detect_alarm_window.sv
`default_nettype none
// ---------------------------------------------------------------------------
// detect_alarm_window : sticky alarm when THRESHOLD detect rises land in a
// WINDOW-cycle window opened by the first rise.            Revision: 1.0
// ---------------------------------------------------------------------------
module detect_alarm_window #(
  parameter int THRESHOLD = 3,
  parameter int WINDOW    = 16,
  parameter int CNT_W     = 4,
  parameter int WIN_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detect,
  input  logic             ack,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WINDOW = 2'd1,
    S_ALARM  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] TIMER_ONE = WIN_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] count_inc;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] timer_nx;
  logic             detect_q;
  logic             rise;

  assign rise      = detect & ~detect_q;
  assign count_inc = event_count + {{(CNT_W-1){1'b0}}, rise};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      event_count <= '0;
      timer       <= '0;
      detect_q    <= 1'b0;
    end else begin
      state       <= state_nx;
      event_count <= count_nx;
      timer       <= timer_nx;
      detect_q    <= detect;
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    count_nx = '0;
    timer_nx = '0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nx = S_WINDOW;
          count_nx = CNT_ONE;
          timer_nx = TIMER_ONE;
        end
      end
      S_WINDOW: begin
        // Threshold wins over expiry, so a rise on the last window edge still counts.
        if (rise && (count_inc == THRESH)) begin
          state_nx = S_ALARM;
          count_nx = count_inc;
          timer_nx = timer;
        end else if (timer == WIN_LAST) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_WINDOW;
          count_nx = count_inc;
          timer_nx = timer + TIMER_ONE;
        end
      end
      S_ALARM: begin
        if (!ack) begin
          state_nx = S_ALARM;
          count_nx = event_count;
          timer_nx = timer;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign alarm = (state == S_ALARM);
  assign busy  = (state == S_WINDOW);

endmodule
`default_nettype wire

// File: tb/tb_detect_alarm_window.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_detect_alarm_window : directed vector bench for detect_alarm_window.
//                                                          Revision: 1.0
// ---------------------------------------------------------------------------
module tb_detect_alarm_window;

  logic       clk = 1'b0;
  logic       reset;
  logic       detect;
  logic       ack;
  logic       alarm;
  logic       busy;
  logic [3:0] event_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       d;
    logic       a;
    logic       al;
    logic       bu;
    logic [3:0] cnt;
  } vec_t;

  vec_t vq[$];

  detect_alarm_window #(
    .THRESHOLD(3),
    .WINDOW   (16),
    .CNT_W    (4),
    .WIN_W    (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .detect     (detect),
    .ack        (ack),
    .alarm      (alarm),
    .busy       (busy),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic al, input logic bu, input logic [3:0] cnt);
    chk("alarm", idx, {3'b0, alarm}, {3'b0, al});
    chk("busy", idx, {3'b0, busy}, {3'b0, bu});
    chk("event_count", idx, event_count, cnt);
  endtask

  task automatic add(input logic d, input logic a, input logic al, input logic bu, input logic [3:0] cnt);
    vec_t v;
    v.d = d; v.a = a; v.al = al; v.bu = bu; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic add_n(input int n, input logic d, input logic a, input logic al, input logic bu,
                       input logic [3:0] cnt);
    for (int i = 0; i < n; i++) add(d, a, al, bu, cnt);
  endtask

  task automatic step(input logic d, input logic a);
    detect = d;
    ack    = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    detect = 1'b0;
    ack    = 1'b0;

    // Threshold at edges 1,5,9; alarm holds; rise in alarm ignored; ack with rise.
    add(1, 0, 0, 1, 1); add_n(3, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 2); add_n(3, 0, 0, 0, 1, 2);
    add(1, 0, 1, 0, 3); add_n(3, 0, 0, 1, 0, 3);
    add(1, 0, 1, 0, 3); add(0, 0, 1, 0, 3);
    add(1, 1, 0, 0, 0); add(0, 0, 0, 0, 0);
    // New window with count 1, ack inside window is ignored, expiry 15 edges later.
    add(1, 0, 0, 1, 1); add(0, 1, 0, 1, 1); add_n(13, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 0);
    // Expiry with rises at 1 and 5.
    add(1, 0, 0, 1, 1); add_n(3, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 2); add_n(10, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0);
    // Boundary: rises at 1,5,16 -> alarm on the last window edge, then ack.
    add(1, 0, 0, 1, 1); add_n(3, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 2); add_n(10, 0, 0, 0, 1, 2);
    add(1, 0, 1, 0, 3); add(0, 1, 0, 0, 0);
    // Boundary: rises at 1,5,17 -> expiry at 16, edge 17 opens a new window.
    add(1, 0, 0, 1, 1); add_n(3, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 2); add_n(10, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0); add(1, 0, 0, 1, 1);
    add_n(14, 0, 0, 0, 1, 1); add(0, 0, 0, 0, 0);
    // Held level for 20 cycles: one event, expiry at edge 16.
    add_n(15, 1, 0, 0, 1, 1); add_n(5, 1, 0, 0, 0, 0); add(0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 1'b0, 1'b0, 4'd0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all(-2, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].d, vq[i].a);
      chk_all(i, vq[i].al, vq[i].bu, vq[i].cnt);
    end

    // Reset mid-alarm, asserted between edges.
    step(1, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
    chk_all(1000, 1'b1, 1'b0, 4'd3);
    detect = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_all(1001, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    step(0, 0);
    chk_all(1002, 1'b0, 1'b0, 4'd0);
    step(0, 0);
    chk_all(1003, 1'b0, 1'b0, 4'd0);

    // Detect already high at reset release counts as a rise on the first edge.
    reset  = 1'b0;
    detect = 1'b1;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all(1004, 1'b0, 1'b1, 4'd1);
    step(1, 0);
    chk_all(1005, 1'b0, 1'b1, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
